// File: rtl/addsub_arbiter.sv
`default_nettype none
// ============================================================================
// addsub_arbiter : round-robin share of one registered 8-bit add/sub datapath
// Revision       : 1.0
// ============================================================================

module addsub (
  input  logic       clk,
  input  logic [7:0] dataa,
  input  logic [7:0] datab,
  input  logic       add_sub,
  output logic [8:0] result
);
  always_ff @(posedge clk) begin
    if (add_sub) result <= {1'b0, dataa} + {1'b0, datab};
    else         result <= {1'b0, dataa} - {1'b0, datab};
  end
endmodule

module addsub_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*8-1:0] req_dataa,
  input  logic [NUM_REQ*8-1:0] req_datab,
  input  logic [NUM_REQ-1:0]   req_add_sub,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [8:0]           rsp_result,
  output logic                 busy
);

  localparam logic [1:0] c_st_idle    = 2'd0;
  localparam logic [1:0] c_st_exec    = 2'd1;
  localparam logic [1:0] c_st_capture = 2'd2;
  localparam logic [1:0] c_st_resp    = 2'd3;

  logic [1:0]      r_state;
  logic [ID_W-1:0] r_rr_ptr;
  logic [7:0]      r_a;
  logic [7:0]      r_b;
  logic            r_op;
  logic [ID_W-1:0] r_id;
  logic            r_rsp_valid;
  logic [ID_W-1:0] r_rsp_id;
  logic [8:0]      r_rsp_result;

  logic            w_gnt_found;
  logic [ID_W-1:0] w_gnt_id;
  logic [ID_W-1:0] w_cand;
  logic            w_accept;
  logic [7:0]      w_a;
  logic [7:0]      w_b;
  logic            w_op;
  logic [8:0]      w_sum;

  // Search starts just after the last winner so every requester gets a turn.
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_id    = '0;
    w_cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = ID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
      if (!w_gnt_found && req_valid[w_cand]) begin
        w_gnt_found = 1'b1;
        w_gnt_id    = w_cand;
      end
    end
  end

  always_comb begin
    w_a  = '0;
    w_b  = '0;
    w_op = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt_id == ID_W'(i)) begin
        w_a  = req_dataa[i*8 +: 8];
        w_b  = req_datab[i*8 +: 8];
        w_op = req_add_sub[i];
      end
    end
  end

  assign w_accept  = (r_state == c_st_idle) && w_gnt_found;
  assign req_ready = w_accept ? (NUM_REQ'(1) << w_gnt_id) : '0;

  addsub u_addsub (
    .clk     (clk),
    .dataa   (r_a),
    .datab   (r_b),
    .add_sub (r_op),
    .result  (w_sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= c_st_idle;
      r_rr_ptr     <= ID_W'(NUM_REQ - 1);
      r_a          <= '0;
      r_b          <= '0;
      r_op         <= 1'b0;
      r_id         <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= '0;
      r_rsp_result <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (w_accept) begin
            r_a      <= w_a;
            r_b      <= w_b;
            r_op     <= w_op;
            r_id     <= w_gnt_id;
            r_rr_ptr <= w_gnt_id;
            r_state  <= c_st_exec;
          end
        end
        c_st_exec: r_state <= c_st_capture;
        // Adder output register was loaded at the end of EXEC.
        c_st_capture: begin
          r_rsp_result <= w_sum;
          r_rsp_id     <= r_id;
          r_rsp_valid  <= 1'b1;
          r_state      <= c_st_resp;
        end
        c_st_resp: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= c_st_idle;
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_result = r_rsp_result;
  assign busy       = (r_state != c_st_idle);

endmodule

`default_nettype wire

// File: tb/tb_addsub_arbiter.sv
`default_nettype none
// ============================================================================
// tb_addsub_arbiter : transaction-level model check plus directed vectors
// Revision          : 1.0
// ============================================================================

module tb_addsub_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*8-1:0] req_dataa;
  logic [NUM_REQ*8-1:0] req_datab;
  logic [NUM_REQ-1:0]   req_add_sub;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [ID_W-1:0]      rsp_id;
  logic [8:0]           rsp_result;
  logic                 busy;

  addsub_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_dataa   (req_dataa),
    .req_datab   (req_datab),
    .req_add_sub (req_add_sub),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_result  (rsp_result),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int f_arith(input int a, input int b, input int op);
    return (op != 0) ? (a + b) : ((a - b + 512) % 512);
  endfunction

  // Model: one op in flight; response visible from accept+3 until taken.
  bit m_init = 1'b0;
  bit m_busy = 1'b0;
  int m_rr, m_acc, m_id, m_res;
  int m_last_res = 0;
  int m_last_id  = 0;

  int acc_id[$];
  int acc_cyc[$];
  int rsp_ids[$];
  int rsp_res[$];
  int rsp_cyc[$];

  always @(negedge clk) begin
    int g;
    logic [NUM_REQ-1:0] e_ready;
    bit e_rv;
    int e_res, e_id;
    cyc++;
    g = -1;
    if (m_init && !m_busy) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        if (g < 0 && req_valid[(m_rr + k) % NUM_REQ]) g = (m_rr + k) % NUM_REQ;
      end
    end
    e_ready = '0;
    if (g >= 0) e_ready[g] = 1'b1;
    e_rv  = m_busy && (cyc >= m_acc + 3);
    e_res = e_rv ? m_res : m_last_res;
    e_id  = e_rv ? m_id  : m_last_id;

    if (m_init) begin
      chk("req_ready",  req_ready,  e_ready);
      chk("busy",       busy,       m_busy);
      chk("rsp_valid",  rsp_valid,  e_rv);
      chk("rsp_result", rsp_result, e_res);
      chk("rsp_id",     rsp_id,     e_id);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          acc_id.push_back(i);
          acc_cyc.push_back(cyc);
        end
      end
      if (rsp_valid && rsp_ready) begin
        rsp_ids.push_back(int'(rsp_id));
        rsp_res.push_back(int'(rsp_result));
        rsp_cyc.push_back(cyc);
      end
    end

    if (rst) begin
      m_init = 1'b1;
      m_busy = 1'b0;
      m_rr   = NUM_REQ - 1;
      m_last_res = 0;
      m_last_id  = 0;
    end else if (m_init) begin
      if (g >= 0) begin
        m_busy = 1'b1;
        m_acc  = cyc;
        m_id   = g;
        m_rr   = g;
        m_res  = f_arith(int'(req_dataa[g*8 +: 8]), int'(req_datab[g*8 +: 8]), int'(req_add_sub[g]));
      end else if (e_rv && rsp_ready) begin
        m_busy     = 1'b0;
        m_last_res = m_res;
        m_last_id  = m_id;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input int a, input int b, input int op, input bit v);
    req_dataa[i*8 +: 8] = a[7:0];
    req_datab[i*8 +: 8] = b[7:0];
    req_add_sub[i]      = (op != 0);
    req_valid[i]        = v;
  endtask

  task automatic wait_acc(input int target, input int max);
    for (int t = 0; t < max && acc_id.size() < target; t++) tick(1);
    chk("accept_seen", acc_id.size() >= target, 1);
  endtask

  task automatic wait_rsp(input int target, input int max);
    for (int t = 0; t < max && rsp_ids.size() < target; t++) tick(1);
    chk("rsp_seen", rsp_ids.size() >= target, 1);
  endtask

  task automatic issue(input int i, input int a, input int b, input int op);
    int n0;
    n0 = acc_id.size();
    set_req(i, a, b, op, 1'b1);
    wait_acc(n0 + 1, 50);
    req_valid[i] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    tick(2);
    chk("rst_req_ready",  req_ready,  0);
    chk("rst_busy",       busy,       0);
    chk("rst_rsp_valid",  rsp_valid,  0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_id",     rsp_id,     0);
    rst = 1'b0;
  endtask

  task automatic reset_mid_op(input bit in_resp);
    int r0, a0;
    do_reset();
    rsp_ready = !in_resp;
    r0 = rsp_ids.size();
    issue(2, 1, 1, 1);
    if (in_resp) begin
      for (int t = 0; t < 10 && !rsp_valid; t++) tick(1);
      chk("mid_rsp_valid_seen", rsp_valid, 1);
    end
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    rsp_ready = 1'b1;
    chk("mid_busy",       busy,       0);
    chk("mid_rsp_valid",  rsp_valid,  0);
    chk("mid_rsp_result", rsp_result, 0);
    chk("mid_rsp_id",     rsp_id,     0);
    tick(4);
    chk("mid_no_rsp", rsp_ids.size(), r0);
    a0 = acc_id.size();
    set_req(3, 20, 5, 0, 1'b1);
    set_req(0, 20, 5, 1, 1'b1);
    wait_acc(a0 + 1, 10);
    chk("mid_first_grant", acc_id[a0], 0);
    req_valid[0] = 1'b0;
    wait_acc(a0 + 2, 20);
    req_valid[3] = 1'b0;
    wait_rsp(r0 + 2, 20);
    chk("mid_res0", rsp_res[r0], 25);
    chk("mid_res3", rsp_res[r0 + 1], 15);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, r0;
    int exp_ids[5] = '{0, 1, 2, 3, 0};
    int exp_res[5] = '{4, 17, 38, 47, 4};
    rst = 1'b1;
    rsp_ready = 1'b1;
    req_valid = '0;
    req_dataa = '0;
    req_datab = '0;
    req_add_sub = '0;
    do_reset();

    // Single add from requester 2
    r0 = rsp_ids.size();
    issue(2, 100, 27, 1);
    wait_rsp(r0 + 1, 20);
    chk("t1_result", rsp_res[r0], 127);
    chk("t1_id", rsp_ids[r0], 2);
    chk("t1_latency", rsp_cyc[r0] - acc_cyc[acc_cyc.size() - 1], 3);

    // Subtract wrap and full-range add
    issue(0, 3, 5, 0);
    wait_rsp(r0 + 2, 20);
    chk("t2_sub_wrap", rsp_res[r0 + 1], 'h1FE);
    issue(1, 255, 255, 1);
    wait_rsp(r0 + 3, 20);
    chk("t2_add_max", rsp_res[r0 + 2], 510);

    // All requesters contending continuously
    do_reset();
    a0 = acc_id.size();
    r0 = rsp_ids.size();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 16 * i + 3, i + 1, (i % 2 == 0), 1'b1);
    wait_acc(a0 + 5, 60);
    req_valid = '0;
    wait_rsp(r0 + 5, 20);
    for (int k = 0; k < 5; k++) begin
      chk("t3_grant_order", acc_id[a0 + k], exp_ids[k]);
      chk("t3_rsp_id", rsp_ids[r0 + k], exp_ids[k]);
      chk("t3_rsp_res", rsp_res[r0 + k], exp_res[k]);
      if (k > 0) chk("t3_spacing", acc_cyc[a0 + k] - acc_cyc[a0 + k - 1], 4);
    end

    // Backpressure held for 10 cycles
    rsp_ready = 1'b0;
    r0 = rsp_ids.size();
    a0 = acc_id.size();
    issue(1, 40, 2, 1);
    set_req(0, 7, 9, 0, 1'b1);
    for (int t = 0; t < 10 && !rsp_valid; t++) tick(1);
    tick(10);
    chk("t4_no_accept", acc_id.size(), a0 + 1);
    chk("t4_held_result", rsp_result, 42);
    chk("t4_held_id", rsp_id, 1);
    rsp_ready = 1'b1;
    tick(1);
    chk("t4_complete_first", rsp_ids.size(), r0 + 1);
    wait_acc(a0 + 2, 10);
    req_valid[0] = 1'b0;
    wait_rsp(r0 + 2, 20);
    chk("t4_second_res", rsp_res[r0 + 1], 510);
    chk("t4_second_id", rsp_ids[r0 + 1], 0);

    // Reset during EXEC, then during RESP
    reset_mid_op(1'b0);
    reset_mid_op(1'b1);

    // Short pulse from requester 1 while busy is dropped
    a0 = acc_id.size();
    r0 = rsp_ids.size();
    issue(0, 9, 9, 1);
    set_req(1, 50, 50, 1, 1'b1);
    tick(1);
    req_valid[1] = 1'b0;
    wait_rsp(r0 + 1, 20);
    tick(6);
    chk("t6_accepts", acc_id.size(), a0 + 1);
    chk("t6_rsps", rsp_ids.size(), r0 + 1);
    chk("t6_rsp_id", rsp_ids[r0], 0);
    chk("t6_rsp_res", rsp_res[r0], 18);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

`default_nettype wire
